// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Package     : lcd_pkg
// Description : Shared definitions for the extremum finder and its LCD text
//               feed: scan FSM state encoding, ASCII anchors and a hex-digit
//               to ASCII helper.
// Revision    : 1.0  initial release
// ============================================================================
package lcd_pkg;

    // Scan controller states, explicitly 2 bits wide.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } fsm_state_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_A    = 8'h41;

    // Uppercase hex digit: 0-9 -> '0'..'9', A-F -> 'A'..'F'.
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return ASCII_ZERO + {4'h0, nib};
        end else begin
            return ASCII_A + {4'h0, nib - 4'd10};
        end
    endfunction

endpackage : lcd_pkg
`default_nettype wire

// File: rtl/btn_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : btn_sync_edge
// Description : Multi-stage synchroniser for an asynchronous switch or push
//               button followed by a one-cycle edge pulse.
//               BOTH_EDGES = 0 : pulse on rising edge only (sync & ~prev)
//               BOTH_EDGES = 1 : pulse on any change    (sync ^  prev)
// Ports       : clk    in  system clock
//               rst_n  in  asynchronous active-low reset
//               din    in  raw asynchronous input
//               pulse  out single-cycle edge indication
// Revision    : 1.0  initial release
// ============================================================================
module btn_sync_edge #(
    parameter int SYNC_STAGES = 2,      // >= 2
    parameter bit BOTH_EDGES  = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   w_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], din};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_level = r_sync[SYNC_STAGES-1];
    assign pulse   = BOTH_EDGES ? (w_level ^ r_prev) : (w_level & ~r_prev);

endmodule : btn_sync_edge
`default_nettype wire

// File: rtl/nway_extremum_finder.sv
`default_nettype none
// ============================================================================
// Module      : nway_extremum_finder
// Description : Holds N_ENTRIES operands loaded from shared switches by
//               individual push buttons, sequentially scans them (one compare
//               per cycle) for the minimum or maximum, and presents the
//               winner's index and value both as binary and as ASCII text.
// Ports       : clk           in   system clock
//               rst_n         in   asynchronous active-low reset
//               load_btn      in   raw buttons, bit i loads entry i
//               holder        in   operand value to load
//               mode          in   raw switch, 0 = min, 1 = max
//               busy          out  scan in progress
//               result_valid  out  result matches current entries and mode
//               result_idx    out  index of the extremum
//               result_val    out  value of the extremum
//               idx_char      out  ASCII digit of result_idx
//               val_chars     out  result_val as uppercase hex ASCII, MS first
// Revision    : 1.0  initial release
// ============================================================================
module nway_extremum_finder
    import lcd_pkg::*;
#(
    parameter  int N_ENTRIES   = 4,     // 2..10
    parameter  int WIDTH       = 4,     // 1..16
    parameter  int SYNC_STAGES = 2,     // >= 2
    localparam int IDX_W       = $clog2(N_ENTRIES),
    localparam int NIBBLES     = (WIDTH + 3) / 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_ENTRIES-1:0]   load_btn,
    input  logic [WIDTH-1:0]       holder,
    input  logic                   mode,
    output logic                   busy,
    output logic                   result_valid,
    output logic [IDX_W-1:0]       result_idx,
    output logic [WIDTH-1:0]       result_val,
    output logic [7:0]             idx_char,
    output logic [8*NIBBLES-1:0]   val_chars
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ENTRIES - 1);

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [N_ENTRIES-1:0] w_load_edge;
    logic                 w_mode_change;
    logic                 r_mode;

    generate
        for (genvar i = 0; i < N_ENTRIES; i++) begin : g_btn
            btn_sync_edge #(
                .SYNC_STAGES (SYNC_STAGES),
                .BOTH_EDGES  (1'b0)
            ) u_btn (
                .clk   (clk),
                .rst_n (rst_n),
                .din   (load_btn[i]),
                .pulse (w_load_edge[i])
            );
        end
    endgenerate

    btn_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .BOTH_EDGES  (1'b1)
    ) u_mode_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (mode),
        .pulse (w_mode_change)
    );

    // The effective compare mode is rebuilt from the change pulses: both it
    // and the synchroniser start at 0, so toggling on every change tracks the
    // synchronised level one cycle later, which is exactly when a scan that
    // was triggered by the change begins comparing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode <= 1'b0;
        end else if (w_mode_change) begin
            r_mode <= ~r_mode;
        end
    end

    // ------------------------------------------------------------------
    // Operand registers
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_entry [N_ENTRIES];
    logic [WIDTH-1:0] w_entry0_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                r_entry[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                if (w_load_edge[i]) begin
                    r_entry[i] <= holder;
                end
            end
        end
    end

    // A scan may start in the same cycle entry 0 is being written; seed the
    // running best with the value entry 0 is about to take.
    assign w_entry0_next = w_load_edge[0] ? holder : r_entry[0];

    // ------------------------------------------------------------------
    // Scan controller
    // ------------------------------------------------------------------
    fsm_state_t       r_state;
    fsm_state_t       w_state_next;
    logic             r_pending;
    logic [IDX_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_best_idx;
    logic [WIDTH-1:0] r_best_val;
    logic [IDX_W-1:0] r_result_idx;
    logic [WIDTH-1:0] r_result_val;
    logic             r_valid;

    logic             w_event;
    logic             w_start;
    logic             w_last;
    logic             w_win;
    logic [WIDTH-1:0] w_cand;

    assign w_event = (|w_load_edge) | w_mode_change;
    // An event seen while idle starts the scan directly so the first compare
    // happens the cycle after the load.
    assign w_start = r_pending | w_event;
    assign w_last  = (r_cnt == LAST_IDX);
    assign w_cand  = r_entry[r_cnt];
    // Strict compares keep the earlier (lower) index on ties.
    assign w_win   = r_mode ? (w_cand > r_best_val) : (w_cand < r_best_val);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_next = SCAN;
                end
            end
            SCAN: begin
                if (w_event) begin
                    w_state_next = IDLE;
                end else if (w_last) begin
                    w_state_next = COMMIT;
                end
            end
            COMMIT: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        busy = (r_state != IDLE);
    end

    // Datapath registers steered by the controller. An event while scanning
    // or committing abandons the pass (no publish) and leaves a request that
    // restarts it from IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending    <= 1'b1;
            r_cnt        <= '0;
            r_best_idx   <= '0;
            r_best_val   <= '0;
            r_result_idx <= '0;
            r_result_val <= '0;
            r_valid      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_pending  <= 1'b0;
                        r_valid    <= 1'b0;
                        r_best_idx <= '0;
                        r_best_val <= w_entry0_next;
                        r_cnt      <= IDX_W'(1);
                    end
                end
                SCAN: begin
                    if (w_event) begin
                        r_pending <= 1'b1;
                    end else begin
                        if (w_win) begin
                            r_best_val <= w_cand;
                            r_best_idx <= r_cnt;
                        end
                        if (!w_last) begin
                            r_cnt <= r_cnt + IDX_W'(1);
                        end
                    end
                end
                COMMIT: begin
                    if (w_event) begin
                        r_pending <= 1'b1;
                    end else begin
                        r_result_idx <= r_best_idx;
                        r_result_val <= r_best_val;
                        r_valid      <= 1'b1;
                    end
                end
                default: begin
                    r_pending <= 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Result and ASCII presentation
    // ------------------------------------------------------------------
    logic [4*NIBBLES-1:0] w_val_ext;

    assign result_valid = r_valid;
    assign result_idx   = r_result_idx;
    assign result_val   = r_result_val;
    assign idx_char     = ASCII_ZERO + 8'(r_result_idx);
    assign w_val_ext    = (4*NIBBLES)'(r_result_val);

    generate
        for (genvar k = 0; k < NIBBLES; k++) begin : g_hex
            assign val_chars[8*k +: 8] = nibble_to_ascii(w_val_ext[4*k +: 4]);
        end
    endgenerate

endmodule : nway_extremum_finder
`default_nettype wire

// File: tb/tb_nway_extremum_finder.sv
`default_nettype none
// ============================================================================
// Module      : tb_nway_extremum_finder
// Description : Self-checking bench for nway_extremum_finder. Instance A is
//               4 x 4-bit, instance B is 8 x 12-bit. A reference model holds
//               the expected operand values and mode and derives the
//               extremum from them; directed literal checks pin key results.
// Revision    : 1.0  initial release
// ============================================================================
module tb_nway_extremum_finder;

    localparam int NA = 4;
    localparam int WA = 4;
    localparam int NB = 8;
    localparam int WB = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic [NA-1:0] btn_a;
    logic [WA-1:0] holder_a;
    logic          mode_a;
    logic          busy_a, valid_a;
    logic [1:0]    idx_a;
    logic [3:0]    val_a;
    logic [7:0]    ichar_a;
    logic [7:0]    vchars_a;

    logic [NB-1:0] btn_b;
    logic [WB-1:0] holder_b;
    logic          mode_b;
    logic          busy_b, valid_b;
    logic [2:0]    idx_b;
    logic [11:0]   val_b;
    logic [7:0]    ichar_b;
    logic [23:0]   vchars_b;

    nway_extremum_finder #(.N_ENTRIES(NA), .WIDTH(WA), .SYNC_STAGES(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .load_btn(btn_a), .holder(holder_a), .mode(mode_a),
        .busy(busy_a), .result_valid(valid_a), .result_idx(idx_a), .result_val(val_a),
        .idx_char(ichar_a), .val_chars(vchars_a)
    );

    nway_extremum_finder #(.N_ENTRIES(NB), .WIDTH(WB), .SYNC_STAGES(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .load_btn(btn_b), .holder(holder_b), .mode(mode_b),
        .busy(busy_b), .result_valid(valid_b), .result_idx(idx_b), .result_val(val_b),
        .idx_char(ichar_b), .val_chars(vchars_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int unsigned ent_a [10];
    int unsigned ent_b [10];
    bit          mx_a, mx_b;
    bit          live_a, live_b;
    int          ea, eb;

    // Extremum value first, then the first index holding it.
    function automatic int model_idx(input int unsigned v[10], input int n, input bit mx);
        int unsigned ext;
        ext = v[0];
        for (int i = 1; i < n; i++) begin
            if (mx ? (v[i] > ext) : (v[i] < ext)) ext = v[i];
        end
        for (int i = 0; i < n; i++) begin
            if (v[i] == ext) return i;
        end
        return 0;
    endfunction

    function automatic logic [31:0] model_hex(input int unsigned v, input int nd);
        logic [31:0] r;
        int unsigned d;
        r = '0;
        for (int k = 0; k < nd; k++) begin
            d = (v >> (4 * k)) & 15;
            r = r | ((d < 10 ? 48 + d : 55 + d) << (8 * k));
        end
        return r;
    endfunction

    // ---------------- continuous compare ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (live_a && valid_a) begin
                ea = model_idx(ent_a, NA, mx_a);
                check("a_idx", 32'(idx_a), ea);
                check("a_val", 32'(val_a), ent_a[ea]);
                check("a_idx_char", 32'(ichar_a), 48 + ea);
                check("a_val_chars", 32'(vchars_a), model_hex(ent_a[ea], 1));
                check("a_idle_when_valid", 32'(busy_a), 0);
            end
            if (live_b && valid_b) begin
                eb = model_idx(ent_b, NB, mx_b);
                check("b_idx", 32'(idx_b), eb);
                check("b_val", 32'(val_b), ent_b[eb]);
                check("b_idx_char", 32'(ichar_b), 48 + eb);
                check("b_val_chars", 32'(vchars_b), model_hex(ent_b[eb], 3));
                check("b_idle_when_valid", 32'(busy_b), 0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Observes result_valid of one instance for `window` cycles, releasing all
    // buttons after cycle `release_at`; reports first fall/rise and counts.
    task automatic watch(input bit which, input int release_at, input int window,
                         output int fall_at, output int rise_at,
                         output int falls, output int rises);
        logic pv, cur;
        fall_at = -1; rise_at = -1; falls = 0; rises = 0;
        pv = which ? valid_b : valid_a;
        for (int c = 1; c <= window; c++) begin
            @(posedge clk); #1;
            if (c == release_at) begin
                btn_a = '0;
                btn_b = '0;
            end
            cur = which ? valid_b : valid_a;
            if (pv && !cur) begin falls++; if (fall_at < 0) fall_at = c; end
            if (!pv && cur) begin rises++; if (rise_at < 0) rise_at = c; end
            pv = cur;
        end
    endtask

    task automatic do_load(input bit which, input int mask, input int unsigned val,
                           output int fa, output int ra);
        int f, r;
        if (!which) begin
            live_a = 0; holder_a = val[3:0]; btn_a = mask[3:0];
            for (int i = 0; i < NA; i++) if (mask[i]) ent_a[i] = val;
        end else begin
            live_b = 0; holder_b = val[11:0]; btn_b = mask[7:0];
            for (int i = 0; i < NB; i++) if (mask[i]) ent_b[i] = val;
        end
        watch(which, 4, 40, fa, ra, f, r);
        check("load_valid_falls", f, 1);
        check("load_valid_rises", r, 1);
        if (!which) live_a = 1; else live_b = 1;
    endtask

    task automatic set_mode_a(input bit m);
        int fa, ra, f, r;
        live_a = 0; mode_a = m; mx_a = m;
        watch(1'b0, 0, 40, fa, ra, f, r);
        check("mode_valid_falls", f, 1);
        check("mode_valid_rises", r, 1);
        live_a = 1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int fa, ra, f1, r1, f2, r2, fx, rx, rise_c;
        rst_n = 0; btn_a = '0; holder_a = '0; mode_a = 0;
        btn_b = '0; holder_b = '0; mode_b = 0;
        live_a = 0; live_b = 0; mx_a = 0; mx_b = 0;
        for (int i = 0; i < 10; i++) begin ent_a[i] = 0; ent_b[i] = 0; end

        // 1: reset state and automatic first scan
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(valid_a), 0);
        check("rst_busy", 32'(busy_a), 0);
        check("rst_idx", 32'(idx_a), 0);
        check("rst_val", 32'(val_a), 0);
        check("rst_idx_char", 32'(ichar_a), 32'h30);
        check("rst_val_chars", 32'(vchars_a), 32'h30);
        rst_n = 1;
        rise_c = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (c == 1) check("post_rst_busy", 32'(busy_a), 1);
            if (valid_a && rise_c < 0) rise_c = c;
        end
        check("post_rst_valid_latency", rise_c, 5);
        live_a = 1; live_b = 1;
        check("post_rst_idx_char", 32'(ichar_a), 32'h30);

        // 2: 7,3,9,5 min then max
        do_load(0, 4'b0001, 7, fa, ra);
        check("load_to_valid_fall", fa, 3);
        check("load_to_valid_rise", ra, 7);
        do_load(0, 4'b0010, 3, fa, ra);
        do_load(0, 4'b0100, 9, fa, ra);
        do_load(0, 4'b1000, 5, fa, ra);
        check("t2_min_idx", 32'(idx_a), 1);
        check("t2_min_val", 32'(val_a), 3);
        check("t2_min_idx_char", 32'(ichar_a), 32'h31);
        check("t2_min_val_chars", 32'(vchars_a), 32'h33);
        set_mode_a(1);
        check("t2_max_idx", 32'(idx_a), 2);
        check("t2_max_val", 32'(val_a), 9);
        check("t2_max_val_chars", 32'(vchars_a), 32'h39);

        // 3: ties resolve to lowest index
        set_mode_a(0);
        do_load(0, 4'b0001, 4, fa, ra);
        do_load(0, 4'b0010, 2, fa, ra);
        do_load(0, 4'b0100, 2, fa, ra);
        do_load(0, 4'b1000, 8, fa, ra);
        check("t3_min_tie_idx", 32'(idx_a), 1);
        check("t3_min_tie_val", 32'(val_a), 2);
        set_mode_a(1);
        do_load(0, 4'b0001, 8, fa, ra);
        do_load(0, 4'b0010, 8, fa, ra);
        do_load(0, 4'b0100, 1, fa, ra);
        do_load(0, 4'b1000, 1, fa, ra);
        check("t3_max_tie_idx", 32'(idx_a), 0);
        check("t3_max_tie_val", 32'(val_a), 8);

        // 4: load edge lands in the second scan cycle of a mode-triggered scan
        live_a = 0; mode_a = 0; mx_a = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        holder_a = 4'd0; btn_a = 4'b1000; ent_a[3] = 0;
        watch(1'b0, 4, 40, fa, ra, fx, rx);
        check("t4_single_fall", fx, 1);
        check("t4_single_publish", rx, 1);
        live_a = 1;
        check("t4_idx", 32'(idx_a), 3);
        check("t4_val", 32'(val_a), 0);

        // 5: simultaneous loads, then a long hold
        do_load(0, 4'b0101, 6, fa, ra);
        check("t5_both_idx", 32'(idx_a), 3);
        do_load(0, 4'b1000, 15, fa, ra);
        check("t5_entry0_idx", 32'(idx_a), 0);
        check("t5_entry0_val", 32'(val_a), 6);
        do_load(0, 4'b0001, 15, fa, ra);
        check("t5_entry2_idx", 32'(idx_a), 2);
        check("t5_entry2_val", 32'(val_a), 6);
        live_a = 0; holder_a = 4'd9; btn_a = 4'b0001; ent_a[0] = 9;
        watch(1'b0, 0, 30, fa, ra, f1, r1);
        holder_a = 4'd0;   // must not be reloaded while the button stays down
        watch(1'b0, 20, 40, fa, ra, f2, r2);
        check("t5_hold_rescans", f1 + f2, 1);
        check("t5_hold_publishes", r1 + r2, 1);
        live_a = 1;
        @(posedge clk); #1;
        check("t5_hold_val", 32'(val_a), 6);

        // 6: wide instance and asynchronous reset mid-scan
        do_load(1, 8'h01, 12'hFFF, fa, ra);
        check("t6_load_to_valid_rise", ra, 11);
        do_load(1, 8'h02, 12'h800, fa, ra);
        do_load(1, 8'h04, 12'h5A5, fa, ra);
        do_load(1, 8'h08, 12'h2B0, fa, ra);
        do_load(1, 8'h10, 12'h7FF, fa, ra);
        do_load(1, 8'h20, 12'h300, fa, ra);
        do_load(1, 8'h40, 12'h1A3, fa, ra);
        do_load(1, 8'h80, 12'h9C4, fa, ra);
        check("t6_idx", 32'(idx_b), 6);
        check("t6_val", 32'(val_b), 32'h1A3);
        check("t6_idx_char", 32'(ichar_b), 32'h36);
        check("t6_val_chars", 32'(vchars_b), 32'h314133);

        live_a = 0; live_b = 0;
        holder_b = 12'h050; btn_b = 8'h02;
        repeat (5) @(posedge clk);
        #1;
        check("t6_busy_before_reset", 32'(busy_b), 1);
        #2 rst_n = 0;
        #1;
        check("t6_rst_valid", 32'(valid_b), 0);
        check("t6_rst_busy", 32'(busy_b), 0);
        check("t6_rst_idx", 32'(idx_b), 0);
        check("t6_rst_val", 32'(val_b), 0);
        check("t6_rst_idx_char", 32'(ichar_b), 32'h30);
        check("t6_rst_val_chars", 32'(vchars_b), 32'h303030);
        check("t6_rst_a_valid", 32'(valid_a), 0);
        btn_b = '0; holder_b = '0;
        for (int i = 0; i < 10; i++) begin ent_a[i] = 0; ent_b[i] = 0; end
        @(posedge clk); #1;
        rst_n = 1;
        rise_c = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (valid_b && rise_c < 0) rise_c = c;
        end
        check("t6_rescan_after_reset", rise_c, 9);
        live_a = 1; live_b = 1;
        check("t6_after_val_chars", 32'(vchars_b), 32'h303030);
        repeat (3) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

endmodule : tb_nway_extremum_finder
`default_nettype wire
